// File: rtl/mmult_pkg.sv
// Shared definitions for the 4x4 matrix multiplier and its result transmitter.
package mmult_pkg;
  localparam int N          = 4;
  localparam int ELEM_W     = 18;
  localparam int HEX_DIGITS = 5;
  localparam int RESULT_W   = 16 * ELEM_W;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_SPACE,
    ST_CR,
    ST_LF
  } tx_state_t;
endpackage

// File: rtl/mmult_result_tx_hex_ascii.sv
// hex_ascii: nibble to uppercase ASCII hex character, purely combinational.
module hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h37 + {4'h0, nibble};
  end
endmodule

// File: rtl/mmult_result_tx.sv
// Captures a 4x4 result word on start and streams it as 4 lines of 5-digit hex text.
// Registered tx_data/tx_valid; holds the character while tx_ready is low.
module mmult_result_tx #(
  parameter int N          = mmult_pkg::N,
  parameter int ELEM_W     = mmult_pkg::ELEM_W,
  parameter int HEX_DIGITS = mmult_pkg::HEX_DIGITS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [0:16*ELEM_W-1]    result,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    done
);
  import mmult_pkg::*;

  tx_state_t            state, state_nxt;
  logic [1:0]           row, col, row_nxt, col_nxt;
  logic [2:0]           digit, digit_nxt;
  logic [0:16*ELEM_W-1] cap, src;
  logic                 load, fin, hs;
  logic [3:0]           nibble;
  logic [7:0]           hex_char, char_nxt;
  int                   base;

  assign hs   = tx_valid & tx_ready;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      row   <= '0;
      col   <= '0;
      digit <= '0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
      digit <= digit_nxt;
      if (load) cap <= result;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    digit_nxt = digit;
    load      = 1'b0;
    fin       = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        load      = 1'b1;
        row_nxt   = '0;
        col_nxt   = '0;
        digit_nxt = '0;
        state_nxt = ST_DIGIT;
      end
      ST_DIGIT: if (hs) begin
        if (digit == 3'(HEX_DIGITS - 1)) begin
          digit_nxt = '0;
          state_nxt = (col == 2'(N - 1)) ? ST_CR : ST_SPACE;
        end else begin
          digit_nxt = digit + 3'd1;
        end
      end
      ST_SPACE: if (hs) begin
        col_nxt   = col + 2'd1;
        digit_nxt = '0;
        state_nxt = ST_DIGIT;
      end
      ST_CR: if (hs) state_nxt = ST_LF;
      ST_LF: if (hs) begin
        col_nxt   = '0;
        digit_nxt = '0;
        if (row == 2'(N - 1)) begin
          state_nxt = ST_IDLE;
          fin       = 1'b1;
        end else begin
          row_nxt   = row + 2'd1;
          state_nxt = ST_DIGIT;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The next character is formed from next-state counters so tx_data can be a flop;
  // on the capture edge the source is the live input, afterwards only the capture register.
  always_comb begin
    src  = load ? result : cap;
    base = (int'(row_nxt) * N + int'(col_nxt)) * ELEM_W;
    if (digit_nxt == 3'd0) nibble = {2'b00, src[base +: 2]};
    else                   nibble = src[base + 2 + (int'(digit_nxt) - 1) * 4 +: 4];
    case (state_nxt)
      ST_DIGIT: char_nxt = hex_char;
      ST_SPACE: char_nxt = ASCII_SP;
      ST_CR:    char_nxt = ASCII_CR;
      ST_LF:    char_nxt = ASCII_LF;
      default:  char_nxt = 8'h00;
    endcase
  end

  hex_ascii u_hex_ascii (
    .nibble (nibble),
    .ascii  (hex_char)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      done     <= 1'b0;
    end else begin
      tx_valid <= (state_nxt != ST_IDLE);
      tx_data  <= char_nxt;
      done     <= fin;
    end
  end
endmodule

// File: tb/tb_mmult_result_tx.sv
// Directed bench for mmult_result_tx with a byte scoreboard checked on every handshake.
module tb_mmult_result_tx;
  logic          clk, reset_n, start, tx_ready;
  logic [0:287]  result;
  logic [7:0]    tx_data;
  logic          tx_valid, busy, done;

  logic [17:0]   elem [16];
  logic [7:0]    sb [$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            accept_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [7:0]    held = 8'h00;
  logic          done_exp = 1'b0;
  int            bc;

  mmult_result_tx dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .result   (result),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  function automatic logic pick(input int duty);
    return (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
  endfunction

  task automatic pack_result();
    for (int i = 0; i < 16; i++) result[i*18 +: 18] = elem[i];
  endtask

  task automatic push_expected();
    logic [17:0] v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        v = elem[4*r + c];
        for (int d = 0; d < 5; d++) sb.push_back(hexc(4'(v >> (16 - 4*d))));
        if (c < 3) sb.push_back(8'h20);
      end
      sb.push_back(8'h0D);
      sb.push_back(8'h0A);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    pack_result();
    start = 1'b1;
    push_expected();
    accept_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("latency_valid", 32'(tx_valid), 32'd1);
    chk("latency_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_cycles(input int n, input int duty);
    repeat (n) begin
      @(posedge clk); #1;
      tx_ready = pick(duty);
    end
  endtask

  task automatic run_until_idle(input int duty, output int cycles);
    logic ok;
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cycles++;
      @(posedge clk); #1;
      tx_ready = pick(duty);
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  // Scoreboard monitor, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("done_pulse", 32'(done), 32'(done_exp));
      if (done_exp) begin
        chk("done_valid_low", 32'(tx_valid), 32'd0);
        chk("done_busy_low", 32'(busy), 32'd0);
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_data", 32'(tx_data), 32'(held));
      end
      done_exp = 1'b0;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          chk("tx_byte", 32'(tx_data), 32'(sb.pop_front()));
          accept_cnt++;
          if (sb.size() == 0) done_exp = 1'b1;
        end
      end
      stall_prev = tx_valid && !tx_ready;
      held = tx_data;
    end
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b0;
    result   = '0;
    #2;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #10 reset_n = 1'b1;

    // All elements 2BCDE, ready held high from the first cycle
    for (int i = 0; i < 16; i++) elem[i] = 18'h2BCDE;
    tx_ready = 1'b1;
    do_start();
    run_until_idle(100, bc);
    chk("busy_cycles_full_rate", 32'(bc), 32'd100);
    chk("accepts_full_rate", 32'(accept_cnt), 32'd100);

    // Identity matrix
    for (int i = 0; i < 16; i++) elem[i] = (i % 5 == 0) ? 18'h00001 : 18'h00000;
    do_start();
    run_until_idle(100, bc);
    chk("sb_empty_identity", 32'(sb.size()), 32'd0);

    // All ones
    for (int i = 0; i < 16; i++) elem[i] = 18'h3FFFF;
    do_start();
    run_until_idle(100, bc);
    chk("sb_empty_ones", 32'(sb.size()), 32'd0);

    // Random backpressure
    for (int i = 0; i < 16; i++) elem[i] = 18'h2BCDE;
    tx_ready = 1'b0;
    do_start();
    run_until_idle(30, bc);
    chk("accepts_random_ready", 32'(accept_cnt), 32'd100);

    // Restart and input change mid-transfer must be ignored
    for (int i = 0; i < 16; i++) elem[i] = 18'h1A2B3 ^ 18'(i * 18'h1111);
    tx_ready = 1'b1;
    do_start();
    run_cycles(20, 100);
    result = ~result;
    start  = 1'b1;
    run_cycles(1, 100);
    start  = 1'b0;
    result = {9{$urandom()}};
    run_until_idle(100, bc);
    run_cycles(10, 100);
    chk("no_second_xfer_busy", 32'(busy), 32'd0);
    chk("accepts_restart", 32'(accept_cnt), 32'd100);

    // Asynchronous reset mid-transfer
    for (int i = 0; i < 16; i++) elem[i] = 18'(i * 18'h2345 + 18'h0F0F);
    do_start();
    for (int i = 0; i < 500; i++) begin
      if (accept_cnt >= 37) break;
      run_cycles(1, 100);
    end
    chk("reached_char_37", 32'(accept_cnt), 32'd37);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_data", 32'(tx_data), 32'h00);
    sb.delete();
    stall_prev = 1'b0;
    done_exp   = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    do_start();
    run_until_idle(100, bc);
    chk("busy_cycles_after_reset", 32'(bc), 32'd100);
    chk("accepts_after_reset", 32'(accept_cnt), 32'd100);
    run_cycles(3, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
